demux8_sched: RTL
=================

# demux8_sched

Credit-based round-robin scheduler that steers a stream of words onto one of eight destinations through the 1x8 demultiplexer datapath. It accepts words from an upstream valid/ready source, chooses the next destination that still holds credit, drives the demux select lines and data, and pulses a one-cycle strobe. It sits directly in front of the demux1x8 and owns all sequencing of its select inputs.

## Interface
- DW, 8, data word width
- CREDITS, 4, per-channel credit count loaded at reset (1..15)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  DW  upstream word
- in_valid  in  1  upstream word present
- in_ready  out  1  word consumed this cycle
- credit_ret  in  8  bit k pulses high for one cycle when destination k frees one slot
- d  out  DW  data to demux
- s2, s1, s0  out  1 each  demux select, s2 = MSB, channel = {s2,s1,s0}
- d_valid  out  1  one-cycle strobe, d/s* valid
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky, set on credit overflow; cleared only by rst

## Operation
- State machine: IDLE, ARB, SEND, STALL.
- IDLE: if in_valid, go ARB.
- ARB: search channels ptr, ptr+1, ... ptr+7 (mod 8) for first with credit > 0; found -> latch grant, go SEND; none -> go STALL.
- STALL: each cycle repeat the search; go SEND when a channel has credit. in_valid dropping in STALL returns to IDLE.
- SEND: d = in_data, {s2,s1,s0} = grant, d_valid = 1, in_ready = 1; credit[grant] decrements; ptr = grant + 1 (mod 8, 7 wraps to 0); go IDLE.
- Credits: 4-bit counters, reset to CREDITS. credit_ret[k] increments credit[k]; decrement on send to k; same-cycle send and return on k leaves it unchanged. Return when credit[k] == CREDITS is dropped (saturate) and sets err.
- Outside SEND: d_valid = 0, in_ready = 0; d and s* hold last sent values.
- Upstream must hold in_data/in_valid stable from assertion until in_ready.

## Timing
- Reset values: in_ready 0, d 0, s2/s1/s0 0, d_valid 0, busy 0, err 0, ptr 0, all credits = CREDITS, state IDLE.
- d, s*, d_valid, in_ready are registered (driven from SEND state).
- Latency with credit available: in_valid high in cycle N (IDLE) -> ARB N+1 -> SEND N+2 (d_valid, in_ready). Throughput one word per 3 cycles.
- Credit returned at cycle M is visible to the search at cycle M+1.
- Reset asserted mid-operation: all state and outputs return to reset values immediately; a word in ARB/STALL/SEND is not consumed and must be re-presented.

## Configuration
- DEMUX8_SCHED_STATS_EN defined: adds per-channel 16-bit sent counters (reset 0, increment in SEND for the granted channel, wrap 65535 -> 0) and ports stat_idx in 3 / stat_cnt out 16; stat_cnt = counter[stat_idx] combinationally.
- Not defined: no counters, no stat ports; scheduling behaviour identical.

## Test plan
- Reset then 8 back-to-back words 0x10..0x17 with no returns -> channels 0,1,...,7 in order, d_valid every 3rd cycle, first strobe 2 cycles after in_valid.
- CREDITS=4, 32 words, no returns -> 4 rounds of 0..7; 33rd word holds in STALL, busy=1, in_ready=0; credit_ret[5] pulse -> word sent to channel 5, ptr becomes 6.
- Credits: 0 on all but channels 2 and 6 -> words alternate 2,6,2,6 (skip logic, wrap 6 -> 2 via 7,0,1).
- credit_ret[3] while credit[3]=CREDITS -> credit stays 4, err=1 and remains 1 until rst.
- Send to channel 4 with credit_ret[4] in same cycle -> credit[4] unchanged; rst asserted during SEND -> d_valid/in_ready fall immediately, ptr=0, credits restored.
- With DEMUX8_SCHED_STATS_EN: 10 words, no stalls -> stat_cnt for idx 0,1 = 2, idx 2..7 = 1.

Source files
------------

// File: rtl/demux8_sched.sv
// demux8_sched: credit-based round-robin scheduler driving the select and data
// inputs of a 1x8 demultiplexer from an upstream valid/ready word stream.
// Optional feature macro: DEMUX8_SCHED_STATS_EN adds per-channel sent counters
// readable through stat_idx/stat_cnt.
module demux8_sched #(
  parameter int unsigned DW      = 8,
  parameter int unsigned CREDITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    credit_ret,
  output logic [DW-1:0] d,
  output logic          s2,
  output logic          s1,
  output logic          s0,
  output logic          d_valid,
  output logic          busy,
  output logic          err
`ifdef DEMUX8_SCHED_STATS_EN
  ,
  input  logic [2:0]    stat_idx,
  output logic [15:0]   stat_cnt
`endif
);

  localparam int unsigned NCH = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned SW  = 3;

  typedef enum logic [1:0] {IDLE, ARB, SEND, STALL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   credit_q [NCH];
  logic [CW-1:0]   credit_d [NCH];
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   grant_q, grant_d;
  logic [DW-1:0]   d_q, d_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            d_valid_q, d_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            found_c;
  logic [SW-1:0]   found_idx_c;
  logic [SW-1:0]   cand_c;

  // Round-robin search from ptr for the first channel holding credit
  always_comb begin
    found_c     = 1'b0;
    found_idx_c = '0;
    cand_c      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand_c = ptr_q + SW'(i);
      if (!found_c && (credit_q[cand_c] != '0)) begin
        found_c     = 1'b1;
        found_idx_c = cand_c;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; STALL re-runs the search every cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ARB;
      ARB:     state_d = found_c ? SEND : STALL;
      STALL: begin
        if (!in_valid)    state_d = IDLE;
        else if (found_c) state_d = SEND;
      end
      SEND:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; outputs are loaded on entry to SEND so they
  // are valid during the SEND cycle itself
  always_comb begin
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    d_d        = d_q;
    sel_d      = sel_q;
    d_valid_d  = 1'b0;
    in_ready_d = 1'b0;
    busy_d     = (state_d != IDLE);
    if ((state_q == ARB || state_q == STALL) && state_d == SEND) begin
      grant_d = found_idx_c;
    end
    if (state_d == SEND) begin
      d_d        = in_data;
      sel_d      = grant_d;
      d_valid_d  = 1'b1;
      in_ready_d = 1'b1;
    end
    if (state_q == SEND) begin
      ptr_d = grant_q + SW'(1);
    end
  end

  // Credit counters: return increments, send decrements, both cancel;
  // a return onto a full counter is dropped and flags err
  always_comb begin
    err_d = err_q;
    for (int k = 0; k < NCH; k++) begin
      credit_d[k] = credit_q[k];
      if (credit_ret[k] && !(state_q == SEND && grant_q == SW'(k))) begin
        if (credit_q[k] == CW'(CREDITS)) err_d = 1'b1;
        else                             credit_d[k] = credit_q[k] + CW'(1);
      end else if (!credit_ret[k] && state_q == SEND && grant_q == SW'(k)) begin
        credit_d[k] = credit_q[k] - CW'(1);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      grant_q    <= '0;
      d_q        <= '0;
      sel_q      <= '0;
      d_valid_q  <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int k = 0; k < NCH; k++) credit_q[k] <= CW'(CREDITS);
    end else begin
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      d_q        <= d_d;
      sel_q      <= sel_d;
      d_valid_q  <= d_valid_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      for (int k = 0; k < NCH; k++) credit_q[k] <= credit_d[k];
    end
  end

  assign d            = d_q;
  assign {s2, s1, s0} = sel_q;
  assign d_valid      = d_valid_q;
  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign err          = err_q;

`ifdef DEMUX8_SCHED_STATS_EN
  logic [15:0] stat_q [NCH];

  // Per-channel sent counters, wrapping at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) stat_q[k] <= '0;
    end else if (state_q == SEND) begin
      stat_q[grant_q] <= stat_q[grant_q] + 16'd1;
    end
  end

  assign stat_cnt = stat_q[stat_idx];
`endif

endmodule
